// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor with valid/ready handshake.
// The carry chain is cut into STAGES chunks, one chunk resolved per stage.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SUB,
    input  logic             CIN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             V,
    output logic             Z
);

    localparam int CHUNK = WIDTH / STAGES;

    logic             en;
    logic             out_vld;
    logic [WIDTH-1:0] b_eff;

    assign en       = !out_vld || OUT_READY;
    assign IN_READY = en;
    assign b_eff    = SUB ? ~B : B;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int DONE = k * CHUNK;
        localparam int REM  = WIDTH - DONE;

        logic [REM-1:0]        a_in;
        logic [REM-1:0]        b_in;
        logic                  c_in;
        logic                  vld_in;
        logic [CHUNK:0]        part;
        logic [DONE+CHUNK-1:0] s_d;
        logic [DONE+CHUNK-1:0] s_q;
        logic                  vld_d;
        logic                  vld_q;

        always_comb begin
            part = {1'b0, a_in[CHUNK-1:0]}
                 + {1'b0, b_in[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, c_in};
        end

        always_comb begin
            vld_d = vld_q;
            if (en) begin
                vld_d = vld_in;
            end
        end

        if (k == 0) begin : g_head
            assign a_in   = A;
            assign b_in   = b_eff;
            assign c_in   = CIN;
            assign vld_in = IN_VALID;

            always_comb begin
                s_d = s_q;
                if (en) begin
                    s_d = part[CHUNK-1:0];
                end
            end
        end else begin : g_link
            // Operands and carry come from the previous stage's skew regs.
            assign a_in   = g_st[k-1].g_pass.a_q;
            assign b_in   = g_st[k-1].g_pass.b_q;
            assign c_in   = g_st[k-1].g_pass.c_q;
            assign vld_in = g_st[k-1].vld_q;

            always_comb begin
                s_d = s_q;
                if (en) begin
                    s_d = {part[CHUNK-1:0], g_st[k-1].s_q};
                end
            end
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                vld_q <= 1'b0;
                s_q   <= '0;
            end else begin
                vld_q <= vld_d;
                s_q   <= s_d;
            end
        end

        if (k < STAGES - 1) begin : g_pass
            localparam int NXT = REM - CHUNK;

            logic [NXT-1:0] a_d;
            logic [NXT-1:0] a_q;
            logic [NXT-1:0] b_d;
            logic [NXT-1:0] b_q;
            logic           c_d;
            logic           c_q;

            always_comb begin
                a_d = a_q;
                b_d = b_q;
                c_d = c_q;
                if (en) begin
                    a_d = a_in[REM-1:CHUNK];
                    b_d = b_in[REM-1:CHUNK];
                    c_d = part[CHUNK];
                end
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    a_q <= '0;
                    b_q <= '0;
                    c_q <= 1'b0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                    c_q <= c_d;
                end
            end
        end else begin : g_tail
            logic c_d;
            logic c_q;
            logic v_d;
            logic v_q;
            logic z_d;
            logic z_q;

            // Top chunk holds the MSBs, so overflow is decided here.
            always_comb begin
                c_d = c_q;
                v_d = v_q;
                z_d = z_q;
                if (en) begin
                    c_d = part[CHUNK];
                    v_d = (a_in[CHUNK-1] == b_in[CHUNK-1])
                       && (part[CHUNK-1] != a_in[CHUNK-1]);
                    z_d = (s_d == '0);
                end
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                    z_q <= 1'b0;
                end else begin
                    c_q <= c_d;
                    v_q <= v_d;
                    z_q <= z_d;
                end
            end
        end
    end

    assign out_vld   = g_st[STAGES-1].vld_q;
    assign OUT_VALID = out_vld;
    assign S         = g_st[STAGES-1].s_q;
    assign C         = g_st[STAGES-1].g_tail.c_q;
    assign V         = g_st[STAGES-1].g_tail.v_q;
    assign Z         = g_st[STAGES-1].g_tail.z_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: 32/4 and 16/1 configurations.
module tb_pipelined_addsub;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic        iv32, ir32, sub32, cin32, ov32, or32, c32, v32, z32;
    logic [31:0] a32, b32, s32;
    logic        iv16, ir16, sub16, cin16, ov16, or16, c16, v16, z16;
    logic [15:0] a16, b16, s16;

    pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut32 (
        .CLK(clk), .RST(rst),
        .IN_VALID(iv32), .IN_READY(ir32),
        .A(a32), .B(b32), .SUB(sub32), .CIN(cin32),
        .OUT_VALID(ov32), .OUT_READY(or32),
        .S(s32), .C(c32), .V(v32), .Z(z32)
    );

    pipelined_addsub #(.WIDTH(16), .STAGES(1)) dut16 (
        .CLK(clk), .RST(rst),
        .IN_VALID(iv16), .IN_READY(ir16),
        .A(a16), .B(b16), .SUB(sub16), .CIN(cin16),
        .OUT_VALID(ov16), .OUT_READY(or16),
        .S(s16), .C(c16), .V(v16), .Z(z16)
    );

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
        bit          lat;
        int          acc;
    } exp_t;

    exp_t sb32[$];
    exp_t sb16[$];
    exp_t m32;
    exp_t m16;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic send32(input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic cin,
                          input logic [31:0] s, input logic c,
                          input logic v, input logic z, input bit lat);
        exp_t e;
        int   tries = 0;
        bit   done = 0;
        iv32 = 1; a32 = a; b32 = b; sub32 = sub; cin32 = cin;
        while (!done) begin
            @(negedge clk);
            if (ir32) begin
                e.s = s; e.c = c; e.v = v; e.z = z;
                e.lat = lat; e.acc = cyc;
                sb32.push_back(e);
                @(posedge clk); #1;
                done = 1;
            end else if (tries > 50) begin
                n_cmp++; n_bad++;
                $display("FAIL send32_timeout: got no accept want accept");
                done = 1;
            end else begin
                tries++;
                @(posedge clk); #1;
            end
        end
        iv32 = 0;
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic cin,
                          input logic [15:0] s, input logic c,
                          input logic v, input logic z);
        exp_t e;
        int   tries = 0;
        bit   done = 0;
        iv16 = 1; a16 = a; b16 = b; sub16 = sub; cin16 = cin;
        while (!done) begin
            @(negedge clk);
            if (ir16) begin
                e.s = {16'h0, s}; e.c = c; e.v = v; e.z = z;
                e.lat = 1; e.acc = cyc;
                sb16.push_back(e);
                @(posedge clk); #1;
                done = 1;
            end else if (tries > 50) begin
                n_cmp++; n_bad++;
                $display("FAIL send16_timeout: got no accept want accept");
                done = 1;
            end else begin
                tries++;
                @(posedge clk); #1;
            end
        end
        iv16 = 0;
    endtask

    task automatic drain32();
        int t = 0;
        while (sb32.size() != 0 && t < 100) begin
            @(posedge clk); t++;
        end
        #1;
        check("drain32_left", sb32.size(), 0);
    endtask

    task automatic drain16();
        int t = 0;
        while (sb16.size() != 0 && t < 100) begin
            @(posedge clk); t++;
        end
        #1;
        check("drain16_left", sb16.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && ov32 && or32) begin
            if (sb32.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL out32_unexpected: got S=%h want no output", s32);
            end else begin
                m32 = sb32.pop_front();
                check("out32_S", s32, m32.s);
                check("out32_C", {31'b0, c32}, {31'b0, m32.c});
                check("out32_V", {31'b0, v32}, {31'b0, m32.v});
                check("out32_Z", {31'b0, z32}, {31'b0, m32.z});
                if (m32.lat) check("out32_latency", cyc - m32.acc, 4);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ov16 && or16) begin
            if (sb16.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL out16_unexpected: got S=%h want no output", s16);
            end else begin
                m16 = sb16.pop_front();
                check("out16_S", {16'h0, s16}, m16.s);
                check("out16_C", {31'b0, c16}, {31'b0, m16.c});
                check("out16_V", {31'b0, v16}, {31'b0, m16.v});
                check("out16_Z", {31'b0, z16}, {31'b0, m16.z});
                if (m16.lat) check("out16_latency", cyc - m16.acc, 1);
            end
        end
    end

    initial begin
        rst = 1;
        iv32 = 0; a32 = 0; b32 = 0; sub32 = 0; cin32 = 0; or32 = 1;
        iv16 = 0; a16 = 0; b16 = 0; sub16 = 0; cin16 = 0; or16 = 1;
        #1;
        check("rst_ov32", {31'b0, ov32}, 0);
        check("rst_s32", s32, 0);
        check("rst_flags32", {29'b0, c32, v32, z32}, 0);
        check("rst_ir32", {31'b0, ir32}, 1);
        check("rst_ov16", {31'b0, ov16}, 0);
        check("rst_s16", {16'h0, s16}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // directed carry / borrow / overflow vectors
        send32(32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 32'h0000_0000, 1, 0, 1, 1);
        send32(32'h00FF_FFFF, 32'h0000_0001, 0, 0, 32'h0100_0000, 0, 0, 0, 1);
        send32(32'h8000_0000, 32'h0000_0001, 1, 1, 32'h7FFF_FFFF, 1, 1, 0, 1);
        send32(32'h0000_0005, 32'h0000_0007, 1, 1, 32'hFFFF_FFFE, 0, 0, 0, 1);
        drain32();

        // back-to-back stream
        send32(32'h1234_5678, 32'h1111_1111, 0, 0, 32'h2345_6789, 0, 0, 0, 1);
        send32(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h8000_0000, 0, 1, 0, 1);
        send32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFE, 1, 0, 0, 1);
        send32(32'h0000_FFFF, 32'h0000_FFFF, 0, 1, 32'h0001_FFFF, 0, 0, 0, 1);
        send32(32'h0000_0000, 32'h0000_0000, 1, 1, 32'h0000_0000, 1, 0, 1, 1);
        send32(32'h0000_0010, 32'h0000_0020, 1, 1, 32'hFFFF_FFF0, 0, 0, 0, 1);
        send32(32'h8000_0000, 32'h8000_0000, 0, 0, 32'h0000_0000, 1, 1, 1, 1);
        send32(32'hA5A5_A5A5, 32'h5A5A_5A5A, 0, 1, 32'h0000_0000, 1, 0, 1, 1);
        drain32();

        // backpressure: fill, stall 3 cycles, then release
        or32 = 0;
        send32(32'h0000_0011, 32'h0000_0022, 0, 0, 32'h0000_0033, 0, 0, 0, 0);
        send32(32'hFFFF_0000, 32'h0001_0000, 0, 0, 32'h0000_0000, 1, 0, 1, 0);
        send32(32'h0000_0100, 32'h0000_0001, 1, 1, 32'h0000_00FF, 1, 0, 0, 0);
        send32(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0, 32'hFFFF_FFFE, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", {31'b0, ir32}, 0);
            check("stall_out_valid", {31'b0, ov32}, 1);
            check("stall_S", s32, sb32[0].s);
            check("stall_C", {31'b0, c32}, {31'b0, sb32[0].c});
        end
        @(posedge clk); #1;
        or32 = 1;
        send32(32'h0000_0003, 32'h0000_0004, 0, 0, 32'h0000_0007, 0, 0, 0, 0);
        send32(32'h8000_0000, 32'h0000_0001, 1, 0, 32'h7FFF_FFFE, 1, 1, 0, 0);
        drain32();

        // reset mid-flight discards everything in the pipe
        or32 = 0;
        send32(32'hFFFF_FFFF, 32'h0000_0002, 0, 0, 32'h0000_0001, 1, 0, 0, 0);
        send32(32'h0000_0002, 32'h0000_0003, 0, 0, 32'h0000_0005, 0, 0, 0, 0);
        send32(32'h0000_0009, 32'h0000_0001, 1, 1, 32'h0000_0008, 1, 0, 0, 0);
        @(posedge clk); #1;
        check("pre_rst_ov32", {31'b0, ov32}, 1);
        check("pre_rst_s32", s32, 32'h0000_0001);
        #2 rst = 1;
        #1;
        check("mid_rst_ov32", {31'b0, ov32}, 0);
        check("mid_rst_s32", s32, 0);
        check("mid_rst_flags32", {29'b0, c32, v32, z32}, 0);
        check("mid_rst_ir32", {31'b0, ir32}, 1);
        sb32.delete();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        or32 = 1;
        send32(32'h0000_0040, 32'h0000_0002, 0, 0, 32'h0000_0042, 0, 0, 0, 1);
        repeat (12) @(posedge clk);
        #1;
        drain32();

        // single-stage 16-bit configuration
        send16(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1);
        send16(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0);
        send16(16'h0003, 16'h0003, 1, 1, 16'h0000, 1, 0, 1);
        drain16();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
